sprite_compositor: RTL and testbench

Parametrised, pipelined pixel compositor that replaces the fixed OR-tree display controller. It holds an attribute table of N rectangular sprites (walls, ball, paddles, score glyph boxes), double-buffered so the game logic can rewrite it mid-frame without tearing. For each incoming pixel coordinate it returns a registered on/off value, a colour index and the winning sprite index, resolved by fixed priority. It sits between the game state machine and the VGA timing generator.

---
 rtl/sprite_compositor_pkg.sv | 40 ++++
 rtl/sprite_compositor_if.sv | 38 +++
 rtl/sprite_compositor_hit.sv | 19 +
 rtl/sprite_compositor.sv | 129 ++++++++++++
 tb/tb_sprite_compositor.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_compositor_pkg.sv
// Shared types and constants for the sprite compositor.
// Provides the sprite attribute record, default parameter values and the
// clipped range test used by every per-slot hit comparator.
package compositor_pkg;

    localparam int unsigned N_SPRITES_DFLT = 8;
    localparam int unsigned COORD_W        = 10;
    localparam int unsigned SIZE_W         = 8;
    localparam int unsigned COLOR_W        = 2;
    localparam int unsigned BLINK_BIT_DFLT = 4;
    localparam int unsigned FRAME_W        = 8;
    // One extra bit so origin + extent never wraps back into the screen.
    localparam int unsigned SUM_W          = COORD_W + 1;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SIZE_W-1:0]  w;
        logic [SIZE_W-1:0]  h;
        logic [COLOR_W-1:0] color;
        logic               visible;
        logic               blink;
    } sprite_attr_t;

    // org <= pos < org + ext, evaluated without wrap-around.
    function automatic logic in_span(
        input logic [COORD_W-1:0] org,
        input logic [SIZE_W-1:0]  ext,
        input logic [COORD_W-1:0] pos
    );
        logic [SUM_W-1:0] lo;
        logic [SUM_W-1:0] hi;
        logic [SUM_W-1:0] p;
        lo = SUM_W'(org);
        hi = lo + SUM_W'(ext);
        p  = SUM_W'(pos);
        return (p >= lo) && (p < hi);
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Bus bundle between game logic / VGA timing (master) and the compositor (slave).
// Carries the shadow-table write port, frame_start, the pixel request and the
// registered compositing result.
interface sprite_compositor_if #(
    parameter int unsigned N_SPRITES = compositor_pkg::N_SPRITES_DFLT
) ();
    localparam int unsigned IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

    logic                                wr_en;
    logic [IDX_W-1:0]                    wr_idx;
    logic [compositor_pkg::COORD_W-1:0]  wr_x;
    logic [compositor_pkg::COORD_W-1:0]  wr_y;
    logic [compositor_pkg::SIZE_W-1:0]   wr_w;
    logic [compositor_pkg::SIZE_W-1:0]   wr_h;
    logic [compositor_pkg::COLOR_W-1:0]  wr_color;
    logic                                wr_visible;
    logic                                wr_blink;
    logic                                frame_start;
    logic                                pix_valid;
    logic [compositor_pkg::COORD_W-1:0]  xpix;
    logic [compositor_pkg::COORD_W-1:0]  ypix;
    logic                                out_valid;
    logic                                pixval;
    logic [compositor_pkg::COLOR_W-1:0]  color;
    logic [IDX_W-1:0]                    hit_idx;

    modport master (
        output wr_en, wr_idx, wr_x, wr_y, wr_w, wr_h, wr_color, wr_visible, wr_blink,
        output frame_start, pix_valid, xpix, ypix,
        input  out_valid, pixval, color, hit_idx
    );

    modport slave (
        input  wr_en, wr_idx, wr_x, wr_y, wr_w, wr_h, wr_color, wr_visible, wr_blink,
        input  frame_start, pix_valid, xpix, ypix,
        output out_valid, pixval, color, hit_idx
    );
endinterface

// File: rtl/sprite_compositor_hit.sv
// Combinational single-slot hit test.
// Ports: attr (active attributes), xpix/ypix (pixel), blink_phase (frame
// counter blink bit), hit_c (slot covers the pixel and is shown this frame).
module sprite_hit
    import compositor_pkg::*;
(
    input  sprite_attr_t       attr,
    input  logic [COORD_W-1:0] xpix,
    input  logic [COORD_W-1:0] ypix,
    input  logic               blink_phase,
    output logic               hit_c
);
    always_comb begin
        hit_c = attr.visible
              && !(attr.blink && blink_phase)
              && in_span(attr.x, attr.w, xpix)
              && in_span(attr.y, attr.h, ypix);
    end
endmodule

// File: rtl/sprite_compositor.sv
// Two-stage pipelined sprite compositor with double-buffered attribute table.
// Ports: clk, reset (sync, active-high), bus (slave modport): shadow-table
// write port, frame_start commit pulse, pixel request, and registered
// out_valid/pixval/color/hit_idx two cycles after the pixel.
module sprite_compositor
    import compositor_pkg::*;
#(
    parameter int unsigned N_SPRITES = N_SPRITES_DFLT,
    parameter int unsigned BLINK_BIT = BLINK_BIT_DFLT
) (
    input  logic                clk,
    input  logic                reset,
    sprite_compositor_if.slave  bus
);
    localparam int unsigned IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

    sprite_attr_t         shadow_q   [N_SPRITES];
    sprite_attr_t         shadow_d   [N_SPRITES];
    sprite_attr_t         active_q   [N_SPRITES];
    sprite_attr_t         active_d   [N_SPRITES];
    sprite_attr_t         wr_attr_c;
    logic [FRAME_W-1:0]   frame_cnt_q;
    logic [FRAME_W-1:0]   frame_cnt_d;

    logic [N_SPRITES-1:0] hit_c;
    logic [N_SPRITES-1:0] s1_hit_q;
    logic [N_SPRITES-1:0] s1_hit_d;
    logic [COLOR_W-1:0]   s1_color_q [N_SPRITES];
    logic [COLOR_W-1:0]   s1_color_d [N_SPRITES];
    logic                 s1_valid_q;
    logic                 s1_valid_d;

    logic                 out_valid_q;
    logic                 out_valid_d;
    logic                 pixval_q;
    logic                 pixval_d;
    logic [COLOR_W-1:0]   color_q;
    logic [COLOR_W-1:0]   color_d;
    logic [IDX_W-1:0]     hit_idx_q;
    logic [IDX_W-1:0]     hit_idx_d;

    // Shadow write, then commit; a write coinciding with commit is included.
    always_comb begin
        wr_attr_c = '{x:       bus.wr_x,
                      y:       bus.wr_y,
                      w:       bus.wr_w,
                      h:       bus.wr_h,
                      color:   bus.wr_color,
                      visible: bus.wr_visible,
                      blink:   bus.wr_blink};
        shadow_d = shadow_q;
        if (bus.wr_en && ((IDX_W+1)'(bus.wr_idx) < (IDX_W+1)'(N_SPRITES))) begin
            shadow_d[bus.wr_idx] = wr_attr_c;
        end
        if (bus.frame_start) begin
            active_d = shadow_d;
        end else begin
            active_d = active_q;
        end
        frame_cnt_d = frame_cnt_q + FRAME_W'(bus.frame_start);
    end

    // Per-slot hit comparators against the active bank.
    for (genvar g = 0; g < int'(N_SPRITES); g++) begin : g_hit
        sprite_hit u_hit (
            .attr        (active_q[g]),
            .xpix        (bus.xpix),
            .ypix        (bus.ypix),
            .blink_phase (frame_cnt_q[BLINK_BIT]),
            .hit_c       (hit_c[g])
        );
    end

    // Stage 1: capture hit vector and the colours it was tested against.
    always_comb begin
        s1_valid_d = bus.pix_valid;
        s1_hit_d   = bus.pix_valid ? hit_c : '0;
        for (int i = 0; i < int'(N_SPRITES); i++) begin
            s1_color_d[i] = active_q[i].color;
        end
    end

    // Stage 2: lowest-index hit wins.
    always_comb begin
        out_valid_d = s1_valid_q;
        pixval_d    = |s1_hit_q;
        color_d     = '0;
        hit_idx_d   = '0;
        for (int i = int'(N_SPRITES) - 1; i >= 0; i--) begin
            if (s1_hit_q[i]) begin
                color_d   = s1_color_q[i];
                hit_idx_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(N_SPRITES); i++) begin
                shadow_q[i]   <= '0;
                active_q[i]   <= '0;
                s1_color_q[i] <= '0;
            end
            frame_cnt_q <= '0;
            s1_hit_q    <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            pixval_q    <= 1'b0;
            color_q     <= '0;
            hit_idx_q   <= '0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            s1_color_q  <= s1_color_d;
            frame_cnt_q <= frame_cnt_d;
            s1_hit_q    <= s1_hit_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            pixval_q    <= pixval_d;
            color_q     <= color_d;
            hit_idx_q   <= hit_idx_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.pixval    = pixval_q;
    assign bus.color     = color_q;
    assign bus.hit_idx   = hit_idx_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: table vectors, directed corner
// sequences and random traffic, all checked through a latency-aware scoreboard.
module tb_sprite_compositor;
    localparam int NS = 8;
    localparam int BB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_compositor_if #(.N_SPRITES(NS)) bus ();

    sprite_compositor #(.N_SPRITES(NS), .BLINK_BIT(BB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int due; bit v; bit pv; int col; int idx; string nm; } exp_t;
    typedef struct { int x; int y; int w; int h; int col; bit vis; bit blk; } m_attr_t;
    typedef struct { int x; int y; bit epv; int ecol; int eidx; } vec_t;

    exp_t    sb[$];
    m_attr_t m_sh[NS];
    m_attr_t m_ac[NS];
    int      m_fc;
    int      cyc;
    int      errs;
    int      checks;

    function automatic m_attr_t blank_attr();
        m_attr_t a;
        a.x = 0; a.y = 0; a.w = 0; a.h = 0; a.col = 0; a.vis = 0; a.blk = 0;
        return a;
    endfunction

    // Reference: first visible, non-blanked slot covering (x,y) in plain integers.
    function automatic exp_t model_px(bit pv, int x, int y);
        exp_t e;
        m_attr_t a;
        e.due = 0; e.v = pv; e.pv = 0; e.col = 0; e.idx = 0; e.nm = "";
        if (pv) begin
            for (int i = NS - 1; i >= 0; i--) begin
                a = m_ac[i];
                if (a.vis && !(a.blk && (((m_fc >> BB) & 1) == 1)) &&
                    x >= a.x && x < a.x + a.w && y >= a.y && y < a.y + a.h) begin
                    e.pv = 1; e.col = a.col; e.idx = i;
                end
            end
        end
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            if (bus.out_valid !== e.v || bus.pixval !== e.pv ||
                bus.color !== 2'(e.col) || bus.hit_idx !== 3'(e.idx)) begin
                errs++;
                $display("FAIL %s cyc=%0d: got v=%b p=%b c=%0d i=%0d, want v=%b p=%b c=%0d i=%0d",
                         e.nm, cyc, bus.out_valid, bus.pixval, bus.color, bus.hit_idx,
                         e.v, e.pv, e.col, e.idx);
            end
        end
    endtask

    // One clock: update the model with the inputs sampled at this edge, then check.
    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                m_sh[i] = blank_attr();
                m_ac[i] = blank_attr();
            end
            m_fc = 0;
            foreach (sb[k]) begin
                sb[k].v = 0; sb[k].pv = 0; sb[k].col = 0; sb[k].idx = 0;
            end
        end else begin
            if (bus.wr_en && int'(bus.wr_idx) < NS) begin
                m_sh[bus.wr_idx].x   = int'(bus.wr_x);
                m_sh[bus.wr_idx].y   = int'(bus.wr_y);
                m_sh[bus.wr_idx].w   = int'(bus.wr_w);
                m_sh[bus.wr_idx].h   = int'(bus.wr_h);
                m_sh[bus.wr_idx].col = int'(bus.wr_color);
                m_sh[bus.wr_idx].vis = bus.wr_visible;
                m_sh[bus.wr_idx].blk = bus.wr_blink;
            end
            if (bus.frame_start) begin
                for (int i = 0; i < NS; i++) m_ac[i] = m_sh[i];
                m_fc = (m_fc + 1) % 256;
            end
        end
        #1;
        check_out();
    endtask

    task automatic step(input bit pv, input int x, input int y, input string nm,
                        input bit fexp = 0, input bit epv = 0, input int ecol = 0,
                        input int eidx = 0);
        exp_t e;
        bus.pix_valid = pv;
        bus.xpix      = 10'(x);
        bus.ypix      = 10'(y);
        e = model_px(pv, x, y);
        if (fexp && pv) begin
            e.pv = epv; e.col = ecol; e.idx = eidx;
        end
        e.due = cyc + 2;
        e.nm  = nm;
        sb.push_back(e);
        cycle();
        bus.wr_en       = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic wr(input int idx, input int x, input int y, input int w, input int h,
                      input int col, input bit vis, input bit blk);
        bus.wr_en      = 1'b1;
        bus.wr_idx     = 3'(idx);
        bus.wr_x       = 10'(x);
        bus.wr_y       = 10'(y);
        bus.wr_w       = 8'(w);
        bus.wr_h       = 8'(h);
        bus.wr_color   = 2'(col);
        bus.wr_visible = vis;
        bus.wr_blink   = blk;
    endtask

    vec_t tab[9];
    int   exp_vis;

    initial begin
        tab = '{'{49, 42, 0, 0, 0}, '{50, 42, 1, 3, 2}, '{55, 42, 1, 3, 2},
                '{59, 42, 1, 3, 2}, '{60, 42, 0, 0, 0}, '{55, 39, 0, 0, 0},
                '{55, 40, 1, 3, 2}, '{55, 44, 1, 3, 2}, '{55, 45, 0, 0, 0}};
        cyc = 0; errs = 0; checks = 0; m_fc = 0;
        for (int i = 0; i < NS; i++) begin
            m_sh[i] = blank_attr();
            m_ac[i] = blank_attr();
        end
        bus.wr_en = 0; bus.wr_idx = 0; bus.wr_x = 0; bus.wr_y = 0; bus.wr_w = 0;
        bus.wr_h = 0; bus.wr_color = 0; bus.wr_visible = 0; bus.wr_blink = 0;
        bus.frame_start = 0; bus.pix_valid = 0; bus.xpix = 0; bus.ypix = 0;

        // Reset, then an empty screen.
        reset = 1'b1;
        step(0, 0, 0, "reset0");
        step(0, 0, 0, "reset1");
        reset = 1'b0;
        step(1, 100, 100, "empty_px", 1, 0, 0, 0);
        step(0, 0, 0, "idle");

        // Slot 2 rectangle, table-driven edges.
        wr(2, 50, 40, 10, 5, 3, 1, 0);
        step(0, 0, 0, "wr_s2");
        bus.frame_start = 1'b1;
        step(0, 0, 0, "commit_s2");
        for (int i = 0; i < 9; i++)
            step(1, tab[i].x, tab[i].y, $sformatf("tab%0d", i), 1, tab[i].epv, tab[i].ecol, tab[i].eidx);
        for (int x = 49; x <= 60; x++) step(1, x, 42, $sformatf("sweep_x%0d", x));

        // Overlap priority.
        wr(1, 190, 190, 20, 20, 1, 1, 0);
        step(0, 0, 0, "wr_s1");
        wr(3, 195, 195, 20, 20, 2, 1, 0);
        step(0, 0, 0, "wr_s3");
        bus.frame_start = 1'b1;
        step(0, 0, 0, "commit_ov");
        step(1, 200, 200, "overlap_s1", 1, 1, 1, 1);
        wr(1, 190, 190, 20, 20, 1, 0, 0);
        step(1, 200, 200, "overlap_pre", 1, 1, 1, 1);
        bus.frame_start = 1'b1;
        step(1, 200, 200, "overlap_fs", 1, 1, 1, 1);
        step(1, 200, 200, "overlap_s3", 1, 1, 2, 3);

        // Double buffering.
        wr(2, 300, 40, 10, 5, 3, 1, 0);
        step(1, 55, 42, "shadow_old", 1, 1, 3, 2);
        step(1, 55, 42, "shadow_old2", 1, 1, 3, 2);
        step(1, 305, 42, "shadow_new", 1, 0, 0, 0);
        bus.frame_start = 1'b1;
        step(0, 0, 0, "commit_300");
        step(1, 55, 42, "commit_old", 1, 0, 0, 0);
        step(1, 305, 42, "commit_new", 1, 1, 3, 2);
        wr(2, 400, 40, 10, 5, 3, 1, 0);
        bus.frame_start = 1'b1;
        step(1, 305, 42, "coinc_pre", 1, 1, 3, 2);
        step(1, 405, 42, "coinc_new", 1, 1, 3, 2);
        step(1, 305, 42, "coinc_old", 1, 0, 0, 0);

        // Right-edge clipping and zero width.
        wr(4, 1020, 0, 10, 4, 2, 1, 0);
        step(0, 0, 0, "wr_s4");
        wr(5, 600, 0, 0, 5, 1, 1, 0);
        step(0, 0, 0, "wr_s5");
        bus.frame_start = 1'b1;
        step(0, 0, 0, "commit_clip");
        step(1, 1019, 1, "clip_1019", 1, 0, 0, 0);
        step(1, 1020, 1, "clip_1020", 1, 1, 2, 4);
        step(1, 1023, 3, "clip_1023", 1, 1, 2, 4);
        step(1, 1023, 4, "clip_y4", 1, 0, 0, 0);
        for (int x = 0; x <= 5; x++) step(1, x, 1, $sformatf("nowrap_x%0d", x), 1, 0, 0, 0);
        for (int x = 598; x <= 602; x++) step(1, x, 2, $sformatf("w0_x%0d", x), 1, 0, 0, 0);

        // Blinking slot across a full frame-counter wrap.
        wr(6, 700, 100, 4, 4, 1, 1, 1);
        step(0, 0, 0, "wr_s6");
        bus.frame_start = 1'b1;
        step(1, 701, 101, "commit_blink");
        for (int f = 0; f < 270; f++) begin
            exp_vis = -1;
            case (m_fc)
                15: exp_vis = 1;
                16: exp_vis = 0;
                31: exp_vis = 0;
                32: exp_vis = 1;
                255: exp_vis = 0;
                0: exp_vis = 1;
                default: exp_vis = -1;
            endcase
            if (exp_vis == 1) step(1, 702, 102, $sformatf("blink_fc%0d", m_fc), 1, 1, 1, 6);
            if (exp_vis == 0) step(1, 702, 102, $sformatf("blink_fc%0d", m_fc), 1, 0, 0, 0);
            bus.frame_start = 1'b1;
            step(1, 701, 101, "blink_frame");
        end

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                wr($urandom_range(0, NS - 1), $urandom_range(0, 1023), $urandom_range(0, 1023),
                   $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3),
                   1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 15) == 0) bus.frame_start = 1'b1;
            step(1'($urandom_range(0, 5) != 0), $urandom_range(0, 1023), $urandom_range(0, 1023), "rand");
        end

        // Reset in the middle of a sweep.
        wr(0, 700, 100, 4, 4, 3, 1, 0);
        bus.frame_start = 1'b1;
        step(0, 0, 0, "commit_s0");
        step(1, 700, 101, "pre_rst0");
        step(1, 701, 101, "pre_rst1");
        reset = 1'b1;
        step(1, 702, 101, "rst_mid");
        reset = 1'b0;
        step(1, 701, 101, "post_rst", 1, 0, 0, 0);
        step(1, 55, 42, "post_rst2", 1, 0, 0, 0);
        step(0, 0, 0, "drain0");
        step(0, 0, 0, "drain1");

        checks++;
        if (sb.size() != 1) begin
            errs++;
            $display("FAIL drain: got %0d pending, want 1", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
